// File: rtl/warp_pc_unit.sv
// Per-warp program-counter bank and round-robin fetch arbiter.
// Holds one PC and an active flag per warp. Each cycle it issues the PC of
// one eligible warp to instruction fetch. It also applies launches, exits
// and redirects from the Task Manager, the SIMT stack and Decode.
module warp_pc_unit #(
  parameter int NUM_WARPS = 8,
  parameter int PC_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Update_TM_PC,
  input  logic [2:0]                    WarpID_TM_PC,
  input  logic [PC_WIDTH-1:0]           StartPC_TM_PC,
  input  logic [NUM_WARPS-1:0]          UpdatePC_Qual1_SIMT_PC,
  input  logic [NUM_WARPS-1:0]          UpdatePC_Qual2_SIMT_PC,
  input  logic [NUM_WARPS-1:0]          Stall_SIMT_PC,
  input  logic [NUM_WARPS*PC_WIDTH-1:0] TargetAddr_SIMT_PC_Flattened,
  input  logic [NUM_WARPS-1:0]          UpdatePC_Qual3_ID_PC,
  input  logic [PC_WIDTH-1:0]           TargetAddr_ID_PC,
  input  logic [NUM_WARPS-1:0]          Exit_ID_PC,
  input  logic [NUM_WARPS-1:0]          Full_IB_PC,
  output logic                          Valid_PC_IF,
  output logic [2:0]                    WarpID_PC_IF,
  output logic [PC_WIDTH-1:0]           PC_PC_IF,
  output logic [NUM_WARPS-1:0]          Active_PC_TM,
  output logic [NUM_WARPS-1:0]          WarpDone_PC_TM
);

  // Returns {grant_valid, grant_id}. The search starts at rr and wraps
  // through all eight warps; the first eligible warp wins.
  function automatic logic [3:0] pick_grant(input logic [7:0] elig,
                                            input logic [2:0] rr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 0; i < 8; i++) begin
      idx = rr + 3'(i);
      if (!res[3] && elig[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [PC_WIDTH-1:0]  pc_q [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] active_q, active_d;
  logic [NUM_WARPS-1:0] done_q, done_d;
  logic [2:0]           rr_q, rr_d;
  logic                 valid_q, valid_d;
  logic [2:0]           wid_q, wid_d;
  logic [PC_WIDTH-1:0]  pcout_q, pcout_d;

  logic [NUM_WARPS-1:0] launch_s;
  logic [NUM_WARPS-1:0] redirect_s;
  logic [NUM_WARPS-1:0] eligible_s;
  logic [3:0]           grant_s;
  logic                 grant_valid_s;
  logic [2:0]           grant_id_s;

  // Decode the launch, block redirected warps from fetch, and pick the grant.
  // A warp that is being rewritten this cycle must not issue its stale PC.
  always_comb begin
    launch_s = {NUM_WARPS{1'b0}};
    if (Update_TM_PC) begin
      launch_s[WarpID_TM_PC] = 1'b1;
    end else begin
      launch_s = {NUM_WARPS{1'b0}};
    end
    redirect_s = UpdatePC_Qual1_SIMT_PC | UpdatePC_Qual2_SIMT_PC |
                 UpdatePC_Qual3_ID_PC | Exit_ID_PC | launch_s;
    eligible_s = active_q & ~Stall_SIMT_PC & ~Full_IB_PC & ~redirect_s;
    grant_s       = pick_grant(eligible_s, rr_q);
    grant_valid_s = grant_s[3];
    grant_id_s    = grant_s[2:0];
  end

  // Per-warp PC and active update, highest-priority source first.
  always_comb begin
    pc_d     = pc_q;
    active_d = active_q;
    done_d   = {NUM_WARPS{1'b0}};
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (launch_s[w]) begin
        pc_d[w]     = StartPC_TM_PC;
        active_d[w] = 1'b1;
      end else if (Exit_ID_PC[w]) begin
        active_d[w] = 1'b0;
        done_d[w]   = 1'b1;
      end else if (UpdatePC_Qual1_SIMT_PC[w]) begin
        pc_d[w] = TargetAddr_SIMT_PC_Flattened[w*PC_WIDTH +: PC_WIDTH];
      end else if (UpdatePC_Qual2_SIMT_PC[w]) begin
        pc_d[w] = TargetAddr_SIMT_PC_Flattened[w*PC_WIDTH +: PC_WIDTH];
      end else if (UpdatePC_Qual3_ID_PC[w]) begin
        pc_d[w] = TargetAddr_ID_PC;
      end else if (grant_valid_s && (grant_id_s == 3'(w))) begin
        pc_d[w] = pc_q[w] + 32'd4;
      end else begin
        pc_d[w] = pc_q[w];
      end
    end
  end

  // Fetch output and round-robin pointer. The ID and PC hold when idle.
  always_comb begin
    valid_d = grant_valid_s;
    if (grant_valid_s) begin
      wid_d   = grant_id_s;
      pcout_d = pc_q[grant_id_s];
      rr_d    = grant_id_s + 3'd1;
    end else begin
      wid_d   = wid_q;
      pcout_d = pcout_q;
      rr_d    = rr_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= {PC_WIDTH{1'b0}};
      end
      active_q <= {NUM_WARPS{1'b0}};
      done_q   <= {NUM_WARPS{1'b0}};
      rr_q     <= 3'd0;
      valid_q  <= 1'b0;
      wid_q    <= 3'd0;
      pcout_q  <= {PC_WIDTH{1'b0}};
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= pc_d[w];
      end
      active_q <= active_d;
      done_q   <= done_d;
      rr_q     <= rr_d;
      valid_q  <= valid_d;
      wid_q    <= wid_d;
      pcout_q  <= pcout_d;
    end
  end

  assign Valid_PC_IF    = valid_q;
  assign WarpID_PC_IF   = wid_q;
  assign PC_PC_IF       = pcout_q;
  assign Active_PC_TM   = active_q;
  assign WarpDone_PC_TM = done_q;

endmodule

// File: tb/tb_warp_pc_unit.sv
// Bench for warp_pc_unit: directed scenarios followed by random traffic.
// Every cycle is checked against a warp-level reference model.
module tb_warp_pc_unit;

  logic         clk;
  logic         rst;
  logic         upd;
  logic [2:0]   wid_tm;
  logic [31:0]  start_pc;
  logic [7:0]   q1, q2, q3, stall, ex, full;
  logic [255:0] tgt_flat;
  logic [31:0]  tgt_id;

  logic         valid_o;
  logic [2:0]   wid_o;
  logic [31:0]  pc_o;
  logic [7:0]   active_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc [8];
  logic [7:0]  m_act;
  int          m_rr;
  logic        m_valid;
  logic [2:0]  m_wid;
  logic [31:0] m_pcout;
  logic [7:0]  m_done;

  warp_pc_unit dut (
    .clk                          (clk),
    .rst                          (rst),
    .Update_TM_PC                 (upd),
    .WarpID_TM_PC                 (wid_tm),
    .StartPC_TM_PC                (start_pc),
    .UpdatePC_Qual1_SIMT_PC       (q1),
    .UpdatePC_Qual2_SIMT_PC       (q2),
    .Stall_SIMT_PC                (stall),
    .TargetAddr_SIMT_PC_Flattened (tgt_flat),
    .UpdatePC_Qual3_ID_PC         (q3),
    .TargetAddr_ID_PC             (tgt_id),
    .Exit_ID_PC                   (ex),
    .Full_IB_PC                   (full),
    .Valid_PC_IF                  (valid_o),
    .WarpID_PC_IF                 (wid_o),
    .PC_PC_IF                     (pc_o),
    .Active_PC_TM                 (active_o),
    .WarpDone_PC_TM               (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 8; w++) m_pc[w] = 32'd0;
    m_act = 8'd0; m_rr = 0; m_valid = 1'b0; m_wid = 3'd0;
    m_pcout = 32'd0; m_done = 8'd0;
  endtask

  // One clock of the warp-level rules, using the current bench inputs
  task automatic model_step();
    logic [7:0] blocked;
    int g;
    int w;
    blocked = q1 | q2 | q3 | ex | stall | full | ~m_act;
    if (upd) blocked[wid_tm] = 1'b1;
    g = -1;
    for (int k = 0; k < 8; k++) begin
      w = (m_rr + k) % 8;
      if (g < 0 && !blocked[w]) g = w;
    end
    m_done = 8'd0;
    if (g >= 0) begin
      m_valid = 1'b1; m_wid = g[2:0]; m_pcout = m_pc[g]; m_rr = (g + 1) % 8;
    end else begin
      m_valid = 1'b0;
    end
    for (int v = 0; v < 8; v++) begin
      if (upd && wid_tm == v[2:0]) begin
        m_pc[v] = start_pc; m_act[v] = 1'b1;
      end else if (ex[v]) begin
        m_act[v] = 1'b0; m_done[v] = 1'b1;
      end else if (q1[v] || q2[v]) begin
        m_pc[v] = tgt_flat[32*v +: 32];
      end else if (q3[v]) begin
        m_pc[v] = tgt_id;
      end else if (v == g) begin
        m_pc[v] = m_pc[v] + 32'd4;
      end
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk); #1;
    check({tag, " valid"},  {31'd0, valid_o}, {31'd0, m_valid});
    check({tag, " warpid"}, {29'd0, wid_o},   {29'd0, m_wid});
    check({tag, " pc"},     pc_o,             m_pcout);
    check({tag, " active"}, {24'd0, active_o}, {24'd0, m_act});
    check({tag, " done"},   {24'd0, done_o},  {24'd0, m_done});
  endtask

  task automatic idle_inputs();
    upd = 1'b0; wid_tm = 3'd0; start_pc = 32'd0;
    q1 = 8'd0; q2 = 8'd0; q3 = 8'd0; stall = 8'd0; ex = 8'd0; full = 8'd0;
    tgt_flat = 256'd0; tgt_id = 32'd0;
  endtask

  task automatic launch(input logic [2:0] w, input logic [31:0] pc, input string tag);
    upd = 1'b1; wid_tm = w; start_pc = pc;
    cycle(tag);
    upd = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b0;
    #12;
    check("reset valid",  {31'd0, valid_o}, 32'd0);
    check("reset pc",     pc_o, 32'd0);
    check("reset active", {24'd0, active_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Two warps alternate
    launch(3'd0, 32'h100, "launch0");
    launch(3'd3, 32'h200, "launch3");
    check("alt1 pc", pc_o, 32'h100);
    cycle("alt2");
    check("alt2 wid", {29'd0, wid_o}, 32'd3);
    check("alt2 pc", pc_o, 32'h200);
    cycle("alt3");
    check("alt3 pc", pc_o, 32'h104);
    cycle("alt4");
    check("alt4 pc", pc_o, 32'h204);

    // Stall warp 3 for three cycles, then it resumes at 0x208
    stall = 8'h08;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      check("stall wid", {29'd0, wid_o}, 32'd0);
    end
    stall = 8'h00;
    cycle("unstall");
    check("unstall pc", pc_o, 32'h208);

    // Qual1 beats Qual3 on warp 0
    q1 = 8'h01; q3 = 8'h01; tgt_id = 32'h800;
    tgt_flat[31:0] = 32'h400;
    cycle("redir");
    check("redir wid", {29'd0, wid_o}, 32'd3);
    q1 = 8'h00; q3 = 8'h00;
    cycle("post redir");
    check("post redir pc", pc_o, 32'h400);

    // Exit warp 3
    ex = 8'h08;
    cycle("exit");
    check("exit done", {24'd0, done_o}, 32'h08);
    ex = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cycle("after exit");
      check("after exit wid", {29'd0, wid_o}, 32'd0);
      check("after exit done", {24'd0, done_o}, 32'd0);
    end

    // All warps launched while IBuffers are full
    full = 8'hFF;
    for (int w = 0; w < 8; w++)
      launch(w[2:0], (w == 1) ? 32'hFFFF_FFFC : 32'h1000 * w, "launch all");
    cycle("all full");
    check("all full valid", {31'd0, valid_o}, 32'd0);
    full = 8'hDF;
    cycle("release5");
    check("release5 wid", {29'd0, wid_o}, 32'd5);
    check("release5 pc", pc_o, 32'h5000);
    full = 8'hFD;
    cycle("wrap1");
    check("wrap1 pc", pc_o, 32'hFFFF_FFFC);
    cycle("wrap2");
    check("wrap2 pc", pc_o, 32'h0);

    // Asynchronous reset mid-stream
    full = 8'h00;
    cycle("pre rst");
    #2; rst = 1'b0; #1;
    check("async valid",  {31'd0, valid_o}, 32'd0);
    check("async wid",    {29'd0, wid_o}, 32'd0);
    check("async pc",     pc_o, 32'd0);
    check("async active", {24'd0, active_o}, 32'd0);
    check("async done",   {24'd0, done_o}, 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      upd      = ($urandom_range(0, 3) == 0);
      wid_tm   = 3'($urandom_range(0, 7));
      start_pc = {$urandom, 2'b00} ^ {$urandom_range(0, 1) == 0 ? 32'hFFFF_FF00 : 32'h0};
      q1       = 8'($urandom & $urandom & $urandom);
      q2       = 8'($urandom & $urandom & $urandom);
      q3       = ($urandom_range(0, 5) == 0) ? 8'(8'd1 << $urandom_range(0, 7)) : 8'd0;
      ex       = ($urandom_range(0, 9) == 0) ? 8'(8'd1 << $urandom_range(0, 7)) : 8'd0;
      stall    = 8'($urandom & $urandom);
      full     = 8'($urandom & $urandom);
      tgt_id   = $urandom;
      for (int w = 0; w < 8; w++) tgt_flat[32*w +: 32] = $urandom;
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/warp_pc_unit.md
Name: warp_pc_unit

Overview:
- Per-warp program-counter bank and fetch arbiter in the Fetch stage.
- Receives warp launches from the Task Manager, and PC redirects and stalls from the SIMT stack and Decode.
- Each cycle it picks one eligible warp round-robin and issues that warp's PC to instruction fetch.
- Acts as the PC-side consumer of the SIMT-to-PC redirect/stall interface.

Parameters:
- NUM_WARPS, 8: number of hardware warps. The RTL supports only 8; the 3-bit warp IDs depend on it.
- PC_WIDTH, 32: width of each PC and of each target-address slice.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- Update_TM_PC  input  1  launch warp WarpID_TM_PC at StartPC_TM_PC
- WarpID_TM_PC  input  3  warp being launched
- StartPC_TM_PC  input  32  launch PC
- UpdatePC_Qual1_SIMT_PC  input  8  per-warp redirect, branch-resolution class
- UpdatePC_Qual2_SIMT_PC  input  8  per-warp redirect, reconvergence-pop class
- Stall_SIMT_PC  input  8  per-warp fetch hold from SIMT
- TargetAddr_SIMT_PC_Flattened  input  256  per-warp target; warp w occupies bits [32w+31:32w]
- UpdatePC_Qual3_ID_PC  input  8  one-hot jump/call redirect from Decode
- TargetAddr_ID_PC  input  32  target for the Qual3 redirect
- Exit_ID_PC  input  8  one-hot warp exit from Decode
- Full_IB_PC  input  8  per-warp IBuffer full; no fetch allowed for that warp
- Valid_PC_IF  output  1  registered fetch valid
- WarpID_PC_IF  output  3  warp of the issued fetch
- PC_PC_IF  output  32  PC of the issued fetch
- Active_PC_TM  output  8  per-warp active flags
- WarpDone_PC_TM  output  8  one-cycle pulse when a warp exits

Behaviour:
- State per warp w: PC[w] (32 bits) and Active[w]. Global state: round-robin pointer RR (3 bits).
- Reset (rst=0, asynchronous):
  - all PC = 0, all Active = 0, RR = 0
  - Valid_PC_IF = 0, WarpID_PC_IF = 0, PC_PC_IF = 0, WarpDone_PC_TM = 0
- Eligible[w] = Active[w] & ~Stall_SIMT_PC[w] & ~Full_IB_PC[w] & ~Redirect[w]
  - Redirect[w] = Qual1[w] | Qual2[w] | Qual3[w] | Exit[w] | (launch targeting w)
- Arbitration (combinational, cycle N):
  - Grant G = first eligible warp searching RR, RR+1, ..., RR+7, modulo 8.
  - If any warp is granted:
    - Valid_PC_IF <= 1, WarpID_PC_IF <= G, PC_PC_IF <= PC[G]
    - PC[G] <= PC[G] + 4, wrapping mod 2^32
    - RR <= G + 1, mod 8
  - If none eligible: Valid_PC_IF <= 0; WarpID and PC outputs hold their values; RR holds.
  - Fetch latency: one cycle from eligibility to registered output.
- PC update priority per warp, applied at the clock edge (highest first):
  1. Launch (Update_TM_PC and WarpID_TM_PC == w): PC <= StartPC_TM_PC, Active <= 1.
  2. Exit_ID_PC[w]: Active <= 0; WarpDone_PC_TM[w] pulses for one cycle; PC unchanged.
  3. Qual1[w]: PC <= TargetAddr slice w.
  4. Qual2[w]: PC <= TargetAddr slice w.
  5. Qual3[w]: PC <= TargetAddr_ID_PC.
  6. Fetch increment (only when G == w; Redirect excludes this case).
- Redirects apply regardless of Active. A redirect to an inactive warp updates PC only and leaves Active at 0.
- Launch of an already active warp restarts it at StartPC with no error.
- Stall and Full only block fetch. They never block a PC update.
- A redirect arriving one cycle after a fetch of the same warp does not cancel the already-issued fetch. Dropping that instruction is the job of IBuffer/SIMT.
- Active_PC_TM is a direct register output.
- Warp ID inputs are 3 bits, so all values 0-7 are legal.

Test Plan:
- Reset, then launch warps 0 and 3 at 0x100 and 0x200, all stalls and fulls low → fetches alternate (0,0x100), (3,0x200), (0,0x104), (3,0x204); Valid_PC_IF = 1 every cycle.
- Warp 3 active, Stall_SIMT_PC[3] = 1 for 3 cycles → no warp-3 fetch during those cycles; next warp-3 fetch resumes at the un-incremented PC.
- UpdatePC_Qual1[0] = 1 and Qual3[0] = 1 in the same cycle, slice0 = 0x400, TargetAddr_ID_PC = 0x800 → warp 0 fetches 0x400 next; no warp-0 fetch in the redirect cycle.
- Exit_ID_PC = 8'h08 → Active_PC_TM[3] clears; WarpDone_PC_TM = 8'h08 for exactly 1 cycle; only warp 0 is fetched afterwards.
- All 8 warps launched, Full_IB_PC = 8'hFF → Valid_PC_IF = 0. Release Full_IB_PC[5] → warp 5 fetched next cycle.
- PC[1] = 0xFFFFFFFC, fetch warp 1 → issued PC 0xFFFFFFFC; next warp-1 PC is 0x0. Assert rst mid-stream → all outputs 0 immediately, asynchronously.
